shifter_seq_iter: RTL and testbench
===================================

// Module: shifter_seq_iter
// PURPOSE
//  Multi-cycle iterative barrel shifter: one shared single-level stage, applied once per cycle.
//  Covers the four shift/rotate ops of the combinational shifter, with a shift count.
//  Processes one count bit per cycle, LSB first: distances 1, 2, 4, 8.
//  Sits beside the ALU for area-constrained builds and connects through valid/ready handshakes.
// PARAMETERS
//  WIDTH   16  data width; must be a power of two
//  CNT_W   4   shift-count width (log2 WIDTH); also the number of SHIFT cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      request present
//  in_ready   out  1      block can accept a request (high only in IDLE)
//  in_data    in   WIDTH  operand
//  in_cnt     in   CNT_W  shift distance, 0..WIDTH-1
//  in_op      in   2      00 ROL, 01 SLL, 10 SRA, 11 SRL
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  shifted result
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; in_ready=1; out_valid=0; out_data=0; internal regs cleared.
//   - Takes effect immediately mid-operation; any request in flight is discarded.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready: latch data, cnt, op; step=0; go to SHIFT.
//  SHIFT (exactly CNT_W cycles, step 0..CNT_W-1):
//   - in_ready=0.
//   - If cnt[step]=1, acc <= stage(acc, 2**step, op); otherwise acc is held.
//   - After step CNT_W-1, go to DONE.
//   - Latency is fixed, independent of cnt: out_valid rises CNT_W+1 cycles after acceptance.
//  DONE:
//   - out_valid=1; out_data=acc, held stable while out_ready=0.
//   - On out_ready=1: go to IDLE, out_valid=0.
//   - No bypass: a new request is accepted at the earliest one cycle after the result handshake.
//  Op semantics per stage (distance d):
//   - ROL: bits leaving the MSB wrap into the LSBs.
//   - SLL: zeros fill the LSBs.
//   - SRA: the MSB of the current acc fills the top d bits.
//   - SRL: zeros fill the top d bits.
//  cnt=0: still runs CNT_W cycles; result equals the operand.
//  Input-side changes while busy are ignored; the latched copy is used.
//  in_valid asserted while out_valid=1 is not accepted (in_ready=0).
// STRUCTURE
//  Shared package shifter_pkg:
//   - op encodings OP_ROL/OP_SLL/OP_SRA/OP_SRL.
//   - state localparams S_IDLE/S_SHIFT/S_DONE.
//  Sub-module shifter_stage_var: combinational, inputs (in, dist_sel, op), outputs out.
//   - dist_sel is one-hot of CNT_W; built from per-bit mux4 selection.
//  Top level: FSM, step counter, acc register, handshake logic.
// TESTING
//  1. ROL 0x8001, cnt=4 -> out_data=0x0018; out_valid exactly 5 cycles after accept.
//  2. SLL 0x8001, cnt=1 -> 0x0002.
//     SRL 0x8000, cnt=15 -> 0x0001.
//  3. SRA 0x8000, cnt=15 -> 0xFFFF.
//     SRA 0x4000, cnt=14 -> 0x0001.
//     cnt=0, any op, 0xA5C3 -> 0xA5C3.
//  4. Back-pressure: hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0.
//     Then out_ready=1 -> in_ready=1 on the next cycle; next request accepted.
//  5. Assert rst during SHIFT step 2 -> out_valid=0, in_ready=1 immediately.
//     After release, the new request SLL 0x0001 cnt=3 -> 0x0008.
//  6. Random sweep: all ops and cnt 0..15 vs. reference model; in_data changed while busy has no effect.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter.
//   - Default data / count widths.
//   - Operation encodings (OP_ROL, OP_SLL, OP_SRA, OP_SRL).
//   - FSM state encoding (S_IDLE, S_SHIFT, S_DONE).
//   - mux4: per-bit operation select used by the shift stage.
package shifter_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Select one of the four candidate bits according to the operation.
  function automatic logic mux4(input logic [1:0] sel,
                                input logic rol_b, input logic sll_b,
                                input logic sra_b, input logic srl_b);
    logic r;
    case (sel)
      OP_ROL:  r = rol_b;
      OP_SLL:  r = sll_b;
      OP_SRA:  r = sra_b;
      OP_SRL:  r = srl_b;
      default: r = srl_b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shifter_stage_var.sv
// Single shared shift/rotate stage with a selectable power-of-two distance.
// Ports:
//   in        in   WIDTH  value to shift
//   dist_sel  in   CNT_W  one-hot distance select (bit k -> distance 2**k);
//                         all-zero passes `in` through unchanged
//   op        in   2      operation (ROL/SLL/SRA/SRL)
//   out       out  WIDTH  shifted value
module shifter_stage_var
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] dist_sel,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out
);

  // cand[k] is `in` shifted by 2**k under the current op.
  logic [CNT_W-1:0][WIDTH-1:0] cand;
  // chain walks the one-hot select; an unselected distance forwards the previous value.
  logic [CNT_W:0][WIDTH-1:0]   chain;

  for (genvar k = 0; k < CNT_W; k++) begin : g_dist
    localparam int D = 2 ** k;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic rol_b;
      logic sll_b;
      logic sra_b;
      logic srl_b;

      assign rol_b = in[(i + WIDTH - D) % WIDTH];

      if (i >= D) begin : g_sll_src
        assign sll_b = in[i - D];
      end else begin : g_sll_fill
        assign sll_b = 1'b0;
      end

      // Right shifts pull from above; past the top, SRA replicates the sign bit.
      if (i + D < WIDTH) begin : g_right_src
        assign sra_b = in[i + D];
        assign srl_b = in[i + D];
      end else begin : g_right_fill
        assign sra_b = in[WIDTH-1];
        assign srl_b = 1'b0;
      end

      assign cand[k][i] = mux4(op, rol_b, sll_b, sra_b, srl_b);
    end
  end

  assign chain[0] = in;
  for (genvar k = 0; k < CNT_W; k++) begin : g_pick
    assign chain[k+1] = dist_sel[k] ? cand[k] : chain[k];
  end

  assign out = chain[CNT_W];

endmodule

// File: rtl/shifter_seq_iter.sv
// Multi-cycle iterative barrel shifter. One count bit is consumed per cycle,
// LSB first, through a single shared stage; latency is fixed at CNT_W+1
// cycles from acceptance to out_valid, regardless of the count.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      request present
//   in_ready   out  1      request can be accepted (only in IDLE)
//   in_data    in   WIDTH  operand
//   in_cnt     in   CNT_W  shift distance
//   in_op      in   2      00 ROL, 01 SLL, 10 SRA, 11 SRL
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_data   out  WIDTH  result, held while out_ready=0
module shifter_seq_iter
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int STEP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 1);

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op;
  logic [CNT_W-1:0]  dist_sel;
  logic [WIDTH-1:0]  stage_out;

  // Distance for the current step; a clear count bit selects nothing so acc is held.
  always_comb begin
    dist_sel = {CNT_W{1'b0}};
    if (cnt[step]) begin
      dist_sel[step] = 1'b1;
    end else begin
      dist_sel = {CNT_W{1'b0}};
    end
  end

  shifter_stage_var #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_stage (
    .in       (acc),
    .dist_sel (dist_sel),
    .op       (op),
    .out      (stage_out)
  );

  // Control FSM, step counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= {STEP_W{1'b0}};
      acc       <= {WIDTH{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      op        <= 2'b00;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= in_data;
            cnt      <= in_cnt;
            op       <= in_op;
            step     <= {STEP_W{1'b0}};
            in_ready <= 1'b0;
            state    <= S_SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_SHIFT: begin
          acc  <= stage_out;
          step <= step + STEP_W'(1);
          if (step == LAST_STEP) begin
            state <= S_DONE;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result; it then stays until taken.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
            out_data  <= acc;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_seq_iter.sv
// Self-checking bench for shifter_seq_iter: directed cases, back-pressure,
// mid-operation reset and a randomized sweep of every op and count, all
// checked against a behavioural model of the shift/rotate rules and the
// fixed-latency handshake.
module tb_shifter_seq_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [3:0]  in_cnt = 4'd0;
  logic [1:0]  in_op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the handshake/latency.
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  int          m_age = 0;
  logic [15:0] m_exp = 16'h0000;
  logic        chk_en = 1'b0;

  localparam int LATENCY = 5;

  always #5 clk = ~clk;

  shifter_seq_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Whole-operation result from plain arithmetic.
  function automatic logic [15:0] ref_fn(input logic [15:0] d, input int c, input logic [1:0] o);
    logic [31:0] dd;
    case (o)
      2'b00: begin
        dd = {d, d} << c;
        return dd[31:16];
      end
      2'b01:   return d << c;
      2'b10:   return 16'($signed(d) >>> c);
      default: return d >> c;
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model state update: accept when idle, count latency, release on handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_age   <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_exp  <= ref_fn(in_data, int'(in_cnt), in_op);
      end
    end else if (!m_valid) begin
      m_age <= m_age + 1;
      if (m_age == LATENCY - 1) m_valid <= 1'b1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("in_ready", {15'd0, in_ready}, {15'd0, !m_busy});
      check("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
      if (m_valid) check("out_data", out_data, m_exp);
    end
  end

  // Issue one request at a negedge, scramble inputs while busy, then drain.
  task automatic do_req(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                        input logic [15:0] exp, input int hold, input string nm);
    int cyc;
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    in_op    = o;
    @(negedge clk);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      in_cnt   = 4'($urandom);
      in_op    = 2'($urandom);
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc != LATENCY) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles expected %0d", nm, cyc, LATENCY);
    end
    check(nm, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      @(negedge clk);
      check({nm, " held"}, out_data, exp);
      check({nm, " busy in_ready"}, {15'd0, in_ready}, 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " ready after"}, {15'd0, in_ready}, 16'd1);
    check({nm, " valid after"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready", {15'd0, in_ready}, 16'd1);
    check("reset out_valid", {15'd0, out_valid}, 16'd0);
    check("reset out_data", out_data, 16'h0000);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Pin the model with hand-computed values.
    check("model rol", ref_fn(16'h8001, 4, 2'b00), 16'h0018);
    check("model sll", ref_fn(16'h8001, 1, 2'b01), 16'h0002);
    check("model srl", ref_fn(16'h8000, 15, 2'b11), 16'h0001);
    check("model sra neg", ref_fn(16'h8000, 15, 2'b10), 16'hFFFF);
    check("model sra pos", ref_fn(16'h4000, 14, 2'b10), 16'h0001);

    // Directed cases with literal expectations.
    do_req(16'h8001, 4'd4,  2'b00, 16'h0018, 0, "rol 8001 4");
    do_req(16'h8001, 4'd1,  2'b01, 16'h0002, 0, "sll 8001 1");
    do_req(16'h8000, 4'd15, 2'b11, 16'h0001, 0, "srl 8000 15");
    do_req(16'h8000, 4'd15, 2'b10, 16'hFFFF, 0, "sra 8000 15");
    do_req(16'h4000, 4'd14, 2'b10, 16'h0001, 0, "sra 4000 14");
    for (int o = 0; o < 4; o++) begin
      do_req(16'hA5C3, 4'd0, 2'(o), 16'hA5C3, 0, "cnt0");
    end

    // Back-pressure, then an immediate next request.
    do_req(16'h1234, 4'd5, 2'b11, 16'h0091, 10, "backpressure");
    do_req(16'h0F0F, 4'd8, 2'b00, 16'h0F0F, 0, "after bp");

    // Reset while step 2 is in progress.
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_cnt   = 4'd7;
    in_op    = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset out_valid", {15'd0, out_valid}, 16'd0);
    check("mid reset in_ready", {15'd0, in_ready}, 16'd1);
    check("mid reset out_data", out_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(16'h0001, 4'd3, 2'b01, 16'h0008, 0, "post reset sll");

    // Randomized sweep: every op and count, random operand and hold time.
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 16; c++) begin
        d = 16'($urandom);
        do_req(d, 4'(c), 2'(o), ref_fn(d, c, 2'(o)), int'($urandom_range(0, 3)), "sweep");
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
